// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between two masters; one access per grant.
// Request-to-ack latency 2+MEM_LATENCY cycles (2 for an illegal op); a losing request waits unchanged.
module mem_arbiter #(
   parameter int MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic [1:0]  op0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   output logic [31:0] rdata0,
   output logic        ack0,
   output logic        err0,
   input  logic        req1,
   input  logic [1:0]  op1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   output logic [31:0] rdata1,
   output logic        ack1,
   output logic        err1,
   output logic [31:0] memop,
   output logic [31:0] memaddress,
   output logic [31:0] memoutdata,
   input  logic [31:0] memindata,
   output logic        busy,
   output logic        grant
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;
   localparam logic [3:0] LAT   = 4'(MEM_LATENCY);

   logic [1:0]  state;
   logic [1:0]  cur_op;
   logic [3:0]  count;
   logic        pick;
   logic [1:0]  pick_op;
   logic [31:0] pick_addr;
   logic [31:0] pick_wdata;
   logic        pick_legal;
   logic        cur_legal;

   // On contention the master that did not own the previous access wins.
   assign pick       = (req0 && req1) ? ~grant : req1;
   assign pick_op    = pick ? op1 : op0;
   assign pick_addr  = pick ? addr1 : addr0;
   assign pick_wdata = pick ? wdata1 : wdata0;
   assign pick_legal = (pick_op == 2'd1) || (pick_op == 2'd2);
   assign cur_legal  = (cur_op == 2'd1) || (cur_op == 2'd2);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cur_op     <= 2'd0;
         count      <= 4'd0;
         memop      <= 32'd0;
         memaddress <= 32'd0;
         memoutdata <= 32'd0;
         rdata0     <= 32'd0;
         rdata1     <= 32'd0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         err0       <= 1'b0;
         err1       <= 1'b0;
         grant      <= 1'b1;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  grant  <= pick;
                  cur_op <= pick_op;
                  state  <= ISSUE;
                  // An illegal op passes through ISSUE without touching the port.
                  if (pick_legal) begin
                     memop      <= {30'd0, pick_op};
                     memaddress <= pick_addr;
                     if (pick_op == 2'd2) begin
                        memoutdata <= pick_wdata;
                     end
                  end
               end
            end
            ISSUE: begin
               memop <= 32'd0;
               count <= LAT;
               if (cur_legal) begin
                  state <= WAIT;
               end else begin
                  state <= DONE;
                  if (grant) begin
                     ack1 <= 1'b1;
                     err1 <= 1'b1;
                  end else begin
                     ack0 <= 1'b1;
                     err0 <= 1'b1;
                  end
               end
            end
            WAIT: begin
               count <= count - 4'd1;
               if (count == 4'd1) begin
                  state <= DONE;
                  if (grant) begin
                     ack1 <= 1'b1;
                     err1 <= 1'b0;
                     if (cur_op == 2'd1) begin
                        rdata1 <= memindata;
                     end
                  end else begin
                     ack0 <= 1'b1;
                     err0 <= 1'b0;
                     if (cur_op == 2'd1) begin
                        rdata0 <= memindata;
                     end
                  end
               end
            end
            default: begin
               // DONE: requests are deliberately not sampled here.
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a latency-1 and a latency-3 instance, each checked every cycle against a
// transaction-level model of arbitration order, access timing and memory contents.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req0 [2], req1 [2], ack0 [2], ack1 [2], err0 [2], err1 [2], busy [2], grant [2];
   logic [1:0]  op0 [2], op1 [2];
   logic [31:0] addr0 [2], addr1 [2], wdata0 [2], wdata1 [2], rdata0 [2], rdata1 [2];
   logic [31:0] memop [2], memaddress [2], memoutdata [2], memindata [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_arbiter #(.MEM_LATENCY(g == 0 ? 1 : 3)) u_dut (
         .clk(clk), .rst(rst),
         .req0(req0[g]), .op0(op0[g]), .addr0(addr0[g]), .wdata0(wdata0[g]),
         .rdata0(rdata0[g]), .ack0(ack0[g]), .err0(err0[g]),
         .req1(req1[g]), .op1(op1[g]), .addr1(addr1[g]), .wdata1(wdata1[g]),
         .rdata1(rdata1[g]), .ack1(ack1[g]), .err1(err1[g]),
         .memop(memop[g]), .memaddress(memaddress[g]), .memoutdata(memoutdata[g]),
         .memindata(memindata[g]), .busy(busy[g]), .grant(grant[g])
      );
   end

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   logic [31:0] mem [logic [32:0]];

   // reference model: at most one outstanding transaction per instance
   bit          act [2];
   int          free_at [2], t_iss [2], t_ack [2];
   bit          t_m [2];
   logic [1:0]  t_op [2];
   logic [31:0] t_addr [2], t_wd [2], t_rd [2];
   logic [31:0] e_rd [2][2], e_maddr [2], e_mout [2];
   bit          e_err [2][2], e_grant [2];

   // memory device and master bookkeeping
   int          pend [2], nrd [2], nwr [2];
   logic [31:0] pend_dat [2];
   int          again [2][2], last_ack [2][2], ord_cnt [2];
   bit          ord [2][256];
   bit          rnd_mode = 1'b0;

   function automatic int lat(int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic bit legal(logic [1:0] op);
      return (op == 2'd1) || (op == 2'd2);
   endfunction

   function automatic logic [31:0] rdval(int i, logic [31:0] a);
      logic [32:0] k;
      k = {i[0], a};
      if (mem.exists(k)) return mem[k];
      return (a * 32'h9E37_79B1) ^ 32'(i + 7);
   endfunction

   task automatic chk(string tag, int i, logic [31:0] got, logic [31:0] exp);
      vectors++;
      assert (got === exp)
      else begin
         miscompares++;
         $error("FAIL %s dut%0d cyc%0d: got %h expected %h", tag, i, cyc, got, exp);
      end
   endtask

   task automatic chk1(string tag, int i, logic got, logic exp);
      vectors++;
      assert (got === exp)
      else begin
         miscompares++;
         $error("FAIL %s dut%0d cyc%0d: got %b expected %b", tag, i, cyc, got, exp);
      end
   endtask

   task automatic set_req(int i, int m, logic on, logic [1:0] op, logic [31:0] a, logic [31:0] w);
      if (m == 0) begin
         req0[i] = on; op0[i] = op; addr0[i] = a; wdata0[i] = w;
      end else begin
         req1[i] = on; op1[i] = op; addr1[i] = a; wdata1[i] = w;
      end
   endtask

   task automatic rand_req(int i, int m);
      int r;
      logic [1:0] op;
      r = int'($urandom_range(0, 10));
      op = (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : (r == 9) ? 2'd3 : 2'd0;
      set_req(i, m, 1'b1, op, 32'h1000_0000 + 32'($urandom_range(0, 15)) * 32'd4, $urandom);
   endtask

   task automatic model_reset(int i);
      act[i] = 1'b0;
      free_at[i] = cyc + 1;
      e_rd[i][0] = 32'd0; e_rd[i][1] = 32'd0;
      e_err[i][0] = 1'b0; e_err[i][1] = 1'b0;
      e_maddr[i] = 32'd0; e_mout[i] = 32'd0;
      e_grant[i] = 1'b1;
   endtask

   // Decide what the arbiter should do with the requests visible at the coming edge.
   task automatic arbitrate(int i);
      bit w;
      if (act[i] || cyc < free_at[i] || !(req0[i] || req1[i])) return;
      w = (req0[i] && req1[i]) ? !e_grant[i] : req1[i];
      t_m[i]    = w;
      t_op[i]   = w ? op1[i] : op0[i];
      t_addr[i] = w ? addr1[i] : addr0[i];
      t_wd[i]   = w ? wdata1[i] : wdata0[i];
      t_rd[i]   = rdval(i, t_addr[i]);
      t_iss[i]  = cyc + 1;
      t_ack[i]  = legal(t_op[i]) ? cyc + 2 + lat(i) : cyc + 2;
      free_at[i] = t_ack[i] + 1;
      act[i] = 1'b1;
   endtask

   task automatic check(int i);
      logic [31:0] x_memop;
      bit at_iss, at_ack;
      at_iss = act[i] && cyc == t_iss[i];
      at_ack = act[i] && cyc == t_ack[i];
      if (at_iss) begin
         e_grant[i] = t_m[i];
         if (legal(t_op[i])) begin
            e_maddr[i] = t_addr[i];
            if (t_op[i] == 2'd2) e_mout[i] = t_wd[i];
         end
      end
      if (at_ack) begin
         e_err[i][t_m[i]] = !legal(t_op[i]);
         if (t_op[i] == 2'd1) e_rd[i][t_m[i]] = t_rd[i];
      end
      x_memop = (at_iss && legal(t_op[i])) ? {30'd0, t_op[i]} : 32'd0;
      chk("memop", i, memop[i], x_memop);
      chk("memaddress", i, memaddress[i], e_maddr[i]);
      chk("memoutdata", i, memoutdata[i], e_mout[i]);
      chk("rdata0", i, rdata0[i], e_rd[i][0]);
      chk("rdata1", i, rdata1[i], e_rd[i][1]);
      chk1("busy", i, busy[i], act[i] && cyc >= t_iss[i]);
      chk1("grant", i, grant[i], e_grant[i]);
      chk1("ack0", i, ack0[i], at_ack && !t_m[i]);
      chk1("ack1", i, ack1[i], at_ack && t_m[i]);
      chk1("err0", i, err0[i], e_err[i][0]);
      chk1("err1", i, err1[i], e_err[i][1]);
      chk1("ack_overlap", i, ack0[i] & ack1[i], 1'b0);
      if (at_ack) act[i] = 1'b0;
   endtask

   task automatic device(int i);
      if (memop[i] == 32'd1) begin
         nrd[i]++;
         pend[i] = cyc + lat(i);
         pend_dat[i] = rdval(i, memaddress[i]);
      end else if (memop[i] == 32'd2) begin
         nwr[i]++;
         mem[{i[0], memaddress[i]}] = memoutdata[i];
      end
      memindata[i] = (pend[i] == cyc) ? pend_dat[i] : $urandom;
   endtask

   task automatic masters(int i);
      for (int m = 0; m < 2; m++) begin
         logic a, r;
         a = (m == 0) ? ack0[i] : ack1[i];
         r = (m == 0) ? req0[i] : req1[i];
         if (a === 1'b1) begin
            last_ack[i][m] = cyc;
            if (ord_cnt[i] < 256) ord[i][ord_cnt[i]] = (m == 1);
            ord_cnt[i]++;
            if (again[i][m] > 0) begin
               again[i][m]--;
               rand_req(i, m);
            end else begin
               set_req(i, m, 1'b0, 2'd0, 32'd0, 32'd0);
            end
         end else if (rnd_mode && !r && $urandom_range(0, 3) == 0) begin
            rand_req(i, m);
         end
      end
   endtask

   task automatic tick();
      for (int i = 0; i < 2; i++) begin
         if (rst) model_reset(i);
         else arbitrate(i);
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 2; i++) begin
         check(i);
         device(i);
         masters(i);
      end
   endtask

   task automatic do_reset();
      for (int i = 0; i < 2; i++) begin
         again[i][0] = 0;
         again[i][1] = 0;
         set_req(i, 0, 1'b0, 2'd0, 32'd0, 32'd0);
         set_req(i, 1, 1'b0, 2'd0, 32'd0, 32'd0);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_ack(int i, int m, int t0);
      for (int k = 0; k < 40 && last_ack[i][m] <= t0; k++) tick();
   endtask

   int t0, s, n;

   initial begin
      for (int i = 0; i < 2; i++) begin
         memindata[i] = 32'd0;
         pend[i] = -1; nrd[i] = 0; nwr[i] = 0; ord_cnt[i] = 0; act[i] = 1'b0;
         last_ack[i][0] = -1; last_ack[i][1] = -1;
      end
      do_reset();
      tick();

      // read, latency 1
      mem[{1'b0, 32'h0040_0000}] = 32'h2008_0005;
      t0 = cyc;
      set_req(0, 0, 1'b1, 2'd1, 32'h0040_0000, 32'd0);
      tick();
      chk("t1_memop", 0, memop[0], 32'd1);
      chk("t1_memaddress", 0, memaddress[0], 32'h0040_0000);
      wait_ack(0, 0, t0);
      chk("t1_latency", 0, 32'(last_ack[0][0] - t0), 32'd3);
      chk("t1_rdata0", 0, rdata0[0], 32'h2008_0005);
      tick();
      chk1("t1_busy_low", 0, busy[0], 1'b0);

      // write from master 1
      n = nwr[0];
      t0 = cyc;
      set_req(0, 1, 1'b1, 2'd2, 32'h1001_0000, 32'hDEAD_BEEF);
      wait_ack(0, 1, t0);
      chk("t2_latency", 0, 32'(last_ack[0][1] - t0), 32'd3);
      chk("t2_write_cycles", 0, 32'(nwr[0] - n), 32'd1);
      chk("t2_memoutdata", 0, memoutdata[0], 32'hDEAD_BEEF);
      chk("t2_rdata1", 0, rdata1[0], 32'd0);

      // contention from reset: four accesses per master
      do_reset();
      s = ord_cnt[0];
      again[0][0] = 3;
      again[0][1] = 3;
      rand_req(0, 0);
      rand_req(0, 1);
      for (int k = 0; k < 200 && ord_cnt[0] < s + 8; k++) tick();
      chk("t3_count", 0, 32'(ord_cnt[0] - s), 32'd8);
      for (int k = 0; k < 8; k++) chk1("t3_order", 0, ord[0][s + k], k[0]);

      // illegal op then legal read
      tick();
      n = nrd[0] + nwr[0];
      t0 = cyc;
      set_req(0, 0, 1'b1, 2'd3, 32'h0000_0080, 32'd0);
      wait_ack(0, 0, t0);
      chk("t4_latency", 0, 32'(last_ack[0][0] - t0), 32'd2);
      chk1("t4_err0", 0, err0[0], 1'b1);
      chk("t4_no_access", 0, 32'(nrd[0] + nwr[0] - n), 32'd0);
      tick();
      t0 = cyc;
      set_req(0, 0, 1'b1, 2'd1, 32'h0000_0084, 32'd0);
      wait_ack(0, 0, t0);
      chk("t4b_latency", 0, 32'(last_ack[0][0] - t0), 32'd3);
      chk1("t4b_err0", 0, err0[0], 1'b0);

      // read with latency 3
      tick();
      mem[{1'b1, 32'h0000_2000}] = 32'h1357_9BDF;
      n = nrd[1];
      t0 = cyc;
      set_req(1, 0, 1'b1, 2'd1, 32'h0000_2000, 32'd0);
      wait_ack(1, 0, t0);
      chk("t5_latency", 1, 32'(last_ack[1][0] - t0), 32'd5);
      chk("t5_rdata0", 1, rdata0[1], 32'h1357_9BDF);
      chk("t5_read_cycles", 1, 32'(nrd[1] - n), 32'd1);

      // reset during WAIT abandons the access
      tick();
      t0 = cyc;
      set_req(1, 0, 1'b1, 2'd1, 32'h0000_2004, 32'd0);
      tick();
      tick();
      do_reset();
      for (int k = 0; k < 6; k++) tick();
      chk1("t6_no_ack", 1, last_ack[1][0] > t0, 1'b0);
      s = ord_cnt[1];
      set_req(1, 0, 1'b1, 2'd1, 32'h0000_2008, 32'd0);
      set_req(1, 1, 1'b1, 2'd1, 32'h0000_200C, 32'd0);
      for (int k = 0; k < 60 && ord_cnt[1] < s + 2; k++) tick();
      chk("t6_count", 1, 32'(ord_cnt[1] - s), 32'd2);
      chk1("t6_first", 1, ord[1][s], 1'b0);
      chk1("t6_second", 1, ord[1][s + 1], 1'b1);

      // random traffic on both instances with one reset in the middle
      rnd_mode = 1'b1;
      for (int k = 0; k < 600; k++) begin
         if (k == 300) do_reset();
         else tick();
      end
      rnd_mode = 1'b0;
      for (int k = 0; k < 200 && (act[0] || act[1] || req0[0] || req1[0] || req0[1] || req1[1]); k++) tick();
      chk1("drain", 0, act[0] || act[1] || req0[0] || req1[0] || req0[1] || req1[1], 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
